rv32i_mem_port: RTL and testbench
=================================

RV32I_MEM_PORT -- requirements
Module: rv32i_mem_port

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning the core address width.
REQ-002 The module SHALL have parameter ADDR_BITS, default 18, meaning the SRAM halfword address width.
REQ-003 The module SHALL have parameter WAIT_STATES, default 2, range 0..15, meaning extra SRAM access cycles.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-005 The module SHALL have port reset_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port memory_addr_i, input, XLEN bits: the core byte address.
REQ-007 The module SHALL have port memory_read_i, input, 1 bit: read request.
REQ-008 The module SHALL have port memory_write_i, input, 1 bit: write request.
REQ-009 The module SHALL have port write_data_i, input, 16 bits: store data in core byte order (lower-address byte in [15:8]).
REQ-010 The module SHALL have port byte_en_i, input, 2 bits: [1] enables the lower-address byte and [0] enables the upper-address byte.
REQ-011 The module SHALL have port read_data_o, output, 16 bits: load data in core byte order.
REQ-012 The module SHALL have ports ready_o, busy_o and fault_o, each output, 1 bit: completion pulse, access in progress, and rejected-request pulse.
REQ-013 The module SHALL have port sram_addr_o, output, ADDR_BITS bits: the halfword address, equal to memory_addr_i[ADDR_BITS:1].
REQ-014 The module SHALL have ports sram_data_i (input, 16 bits) and sram_data_o (output, 16 bits): SRAM data in little-endian order.
REQ-015 The module SHALL have ports sram_ce_o, sram_oe_o and sram_we_o (each output, 1 bit, active-high) and sram_be_o (output, 2 bits), where sram_be_o[0] selects the even byte.

Function
REQ-016 The FSM states SHALL be IDLE, ACCESS and DONE.
REQ-017 A request SHALL be accepted only in IDLE.
REQ-018 On acceptance, the address, data and byte enables SHALL be registered, the wait counter SHALL be loaded with WAIT_STATES, and the FSM SHALL go to ACCESS.
REQ-019 memory_read_i and memory_write_i both high SHALL be treated as a write.
REQ-020 Requests asserted while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-021 In ACCESS, sram_ce_o SHALL be 1, sram_oe_o SHALL equal the read flag, and sram_we_o SHALL equal the write flag.
REQ-022 In ACCESS, the counter SHALL decrement each cycle; at counter==0 the FSM SHALL go to DONE.
REQ-023 On the ACCESS cycle where the counter is 0 and the access is a read, read_data_o SHALL register {sram_data_i[7:0], sram_data_i[15:8]}.
REQ-024 sram_data_o SHALL equal {write_data_i_reg[7:0], write_data_i_reg[15:8]}, and sram_be_o SHALL equal {byte_en_reg[0], byte_en_reg[1]}.
REQ-025 DONE SHALL assert ready_o for exactly one cycle and then return to IDLE.
REQ-026 ready_o SHALL be high in cycle N+WAIT_STATES+2, where N is the acceptance cycle.
REQ-027 read_data_o SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-028 busy_o SHALL be 1 in ACCESS and DONE.
REQ-029 All SRAM strobes SHALL be 0 outside ACCESS.
REQ-030 A request in the same cycle that ready_o is high (DONE) SHALL be ignored; the core SHALL re-issue it in IDLE.

Reset
REQ-031 reset_i SHALL immediately force IDLE and counter=0.
REQ-032 reset_i SHALL immediately force read_data_o=0, ready_o=0, busy_o=0 and fault_o=0.
REQ-033 reset_i SHALL immediately force all SRAM strobes and sram_be_o to 0; sram_addr_o and sram_data_o SHALL be 0.
REQ-034 A reset asserted mid-access SHALL abort the access with no ready_o pulse.

Configuration
REQ-035 When MEM_PORT_FAULT_CHECK_EN is defined, an accepted request SHALL be rejected if memory_addr_i[XLEN-1:ADDR_BITS+1] is nonzero, or if memory_addr_i[0]=1 with byte_en_i=2'b11.
REQ-036 A rejected request SHALL pulse fault_o for one cycle, stay in IDLE, and perform no SRAM access.
REQ-037 When MEM_PORT_FAULT_CHECK_EN is undefined, the upper address bits and memory_addr_i[0] SHALL be ignored, and fault_o SHALL be tied to 0.

Structure
REQ-038 Package rv32i_mem_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the WAIT_STATES maximum.
REQ-039 One sub-module, rv32i_byte_swap (16-bit lane swap), SHALL be instantiated for both read and write paths.

Verification
REQ-040 Bench SHALL cover: WAIT_STATES=2; read at addr 0x10 with SRAM word 0xBEEF at halfword 8, request in cycle 0 -> ready_o in cycle 4 only, read_data_o=0xEFBE.
REQ-041 Bench SHALL cover: write addr 0x22, data 0x1234, byte_en 2'b10 -> sram_addr_o=0x11, sram_we_o high cycles 1-3, sram_be_o=2'b01, sram_data_o=0x3412.
REQ-042 Bench SHALL cover: read_i and write_i both high -> sram_we_o=1 and sram_oe_o=0; a second read issued in cycle 2 -> ignored, single ready_o.
REQ-043 Bench SHALL cover: reset_i pulsed in cycle 2 of a read -> strobes 0 in the same cycle, no ready_o, FSM in IDLE, read_data_o=0.
REQ-044 Bench SHALL cover: with MEM_PORT_FAULT_CHECK_EN, read at 0x0008_0000 -> fault_o one cycle, sram_ce_o stays 0; without the macro -> normal access at halfword 0.
REQ-045 Bench SHALL cover: WAIT_STATES=0 read -> ready_o in cycle 2.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg
// Shared definitions for the RV32I halfword SRAM port:
//   - mem_state_e     : FSM state encoding (IDLE=0, ACCESS=1, DONE=2)
//   - WAIT_STATES_MAX : largest supported WAIT_STATES value
//   - WAIT_CNT_W      : width of the wait-state counter
package rv32i_mem_pkg;

  localparam int WAIT_STATES_MAX = 15;
  localparam int WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/rv32i_byte_swap.sv
// rv32i_byte_swap
// Swaps the two byte lanes of a halfword. The core uses big-endian lane order
// inside a halfword (lower-address byte in [15:8]); the SRAM is little-endian.
// Ports:
//   data_i [15:0] : halfword in one lane order
//   data_o [15:0] : same halfword with byte lanes exchanged
module rv32i_byte_swap (
  input  logic [15:0] data_i,
  output logic [15:0] data_o
);

  assign data_o = {data_i[7:0], data_i[15:8]};

endmodule

// File: rtl/rv32i_mem_port.sv
// rv32i_mem_port
// Bridges single-request core loads/stores onto an asynchronous 16-bit SRAM
// with a programmable number of wait states.
//
// Optional build macro: MEM_PORT_FAULT_CHECK_EN
//   defined   : requests outside the SRAM window, or misaligned full-halfword
//               accesses, are rejected with a one-cycle fault_o pulse.
//   undefined : upper address bits and address bit 0 are ignored; fault_o = 0.
//
// Parameters:
//   XLEN        : core address width
//   ADDR_BITS   : SRAM halfword address width
//   WAIT_STATES : extra SRAM access cycles (0..15)
// Ports:
//   clk_i, reset_i (async, active-high)
//   memory_addr_i, memory_read_i, memory_write_i, write_data_i, byte_en_i
//                 : core request (data in core byte order)
//   read_data_o   : last completed load, core byte order
//   ready_o       : one-cycle completion pulse
//   busy_o        : access in progress (ACCESS or DONE)
//   fault_o       : one-cycle rejected-request pulse
//   sram_addr_o, sram_data_i, sram_data_o, sram_ce_o, sram_oe_o, sram_we_o,
//   sram_be_o     : SRAM side (little-endian, sram_be_o[0] = even byte)
module rv32i_mem_port
  import rv32i_mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_BITS   = 18,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [XLEN-1:0]      memory_addr_i,
  input  logic                 memory_read_i,
  input  logic                 memory_write_i,
  input  logic [15:0]          write_data_i,
  input  logic [1:0]           byte_en_i,
  output logic [15:0]          read_data_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 fault_o,
  output logic [ADDR_BITS-1:0] sram_addr_o,
  input  logic [15:0]          sram_data_i,
  output logic [15:0]          sram_data_o,
  output logic                 sram_ce_o,
  output logic                 sram_oe_o,
  output logic                 sram_we_o,
  output logic [1:0]           sram_be_o
);

  mem_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_BITS-1:0]   addr_q,  addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [1:0]             be_q,    be_d;
  logic                   rd_q,    rd_d;
  logic                   wr_q,    wr_d;
  logic [15:0]            rdata_q, rdata_d;

  logic [15:0]            rdata_swap;
  logic                   req;
  logic                   reject;
  logic                   accept;

  assign req = memory_read_i | memory_write_i;

`ifdef MEM_PORT_FAULT_CHECK_EN
  logic fault_q, fault_d;

  // Outside the SRAM window, or a full halfword starting on an odd byte.
  assign reject = (|memory_addr_i[XLEN-1:ADDR_BITS+1]) |
                  (memory_addr_i[0] & (&byte_en_i));

  assign fault_d = (state_q == IDLE) & req & reject;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end

  assign fault_o = fault_q;
`else
  logic unused_addr_bits;

  assign reject           = 1'b0;
  assign unused_addr_bits = ^{memory_addr_i[XLEN-1:ADDR_BITS+1], memory_addr_i[0]};
  assign fault_o          = 1'b0;
`endif

  // Only an IDLE port takes requests; anything arriving later is dropped.
  assign accept = (state_q == IDLE) & req & ~reject;

  rv32i_byte_swap u_rd_swap (
    .data_i (sram_data_i),
    .data_o (rdata_swap)
  );

  rv32i_byte_swap u_wr_swap (
    .data_i (wdata_q),
    .data_o (sram_data_o)
  );

  // State register plus request/data registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counting and load-data capture.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = WAIT_CNT_W'(WAIT_STATES);
      addr_d  = memory_addr_i[ADDR_BITS:1];
      wdata_d = write_data_i;
      be_d    = byte_en_i;
      // A simultaneous read+write request is a store.
      wr_d    = memory_write_i;
      rd_d    = memory_read_i & ~memory_write_i;
    end else if (state_q == ACCESS) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (rd_q) begin
        // Last SRAM cycle: data is valid, latch it in core byte order.
        rdata_d = rdata_swap;
      end
    end
  end

  // Outputs: strobes only in ACCESS, handshake from state.
  always_comb begin
    sram_ce_o = 1'b0;
    sram_oe_o = 1'b0;
    sram_we_o = 1'b0;
    if (state_q == ACCESS) begin
      sram_ce_o = 1'b1;
      sram_oe_o = rd_q;
      sram_we_o = wr_q;
    end
  end

  assign ready_o     = (state_q == DONE);
  assign busy_o      = (state_q == ACCESS) | (state_q == DONE);
  assign read_data_o = rdata_q;
  assign sram_addr_o = addr_q;
  // Core lane [1] is the lower-address (even) byte, SRAM lane [0] is even.
  assign sram_be_o   = {be_q[0], be_q[1]};

endmodule

// File: tb/tb_rv32i_mem_port.sv
// tb_rv32i_mem_port
// Self-checking bench for rv32i_mem_port: directed scenarios plus randomized
// load/store traffic against a byte-addressed reference memory.
// Two instances: dut (WAIT_STATES=2, backed by an SRAM model) and dut0
// (WAIT_STATES=0, fed a constant SRAM word).
module tb_rv32i_mem_port;

  localparam int XLEN      = 32;
  localparam int ADDR_BITS = 18;
  localparam int WS        = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] wdata = '0;
  logic [1:0]  byte_en = '0;

  logic [15:0] rdata, sram_din, sram_dout;
  logic        ready, busy, fault, sram_ce, sram_oe, sram_we;
  logic [17:0] sram_addr;
  logic [1:0]  sram_be;

  logic [15:0] rdata0, sram0_din, sram0_dout;
  logic        ready0, busy0, fault0, sram0_ce, sram0_oe, sram0_we;
  logic [17:0] sram0_addr;
  logic [1:0]  sram0_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_mem_port #(.XLEN(XLEN), .ADDR_BITS(ADDR_BITS), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .reset_i(reset), .memory_addr_i(addr), .memory_read_i(rd),
    .memory_write_i(wr), .write_data_i(wdata), .byte_en_i(byte_en),
    .read_data_o(rdata), .ready_o(ready), .busy_o(busy), .fault_o(fault),
    .sram_addr_o(sram_addr), .sram_data_i(sram_din), .sram_data_o(sram_dout),
    .sram_ce_o(sram_ce), .sram_oe_o(sram_oe), .sram_we_o(sram_we), .sram_be_o(sram_be)
  );

  rv32i_mem_port #(.XLEN(XLEN), .ADDR_BITS(ADDR_BITS), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .memory_addr_i(addr), .memory_read_i(rd),
    .memory_write_i(wr), .write_data_i(wdata), .byte_en_i(byte_en),
    .read_data_o(rdata0), .ready_o(ready0), .busy_o(busy0), .fault_o(fault0),
    .sram_addr_o(sram0_addr), .sram_data_i(sram0_din), .sram_data_o(sram0_dout),
    .sram_ce_o(sram0_ce), .sram_oe_o(sram0_oe), .sram_we_o(sram0_we), .sram_be_o(sram0_be)
  );

  // Little-endian SRAM model, 64 halfwords; one process owns the array.
  logic [15:0] sram_mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [15:0] pl_val = '0;

  assign sram_din = sram_mem[sram_addr[5:0]];

  always @(posedge clk) begin
    if (pl_en) begin
      sram_mem[pl_addr] <= pl_val;
    end else if (sram_ce && sram_we) begin
      if (sram_be[0]) sram_mem[sram_addr[5:0]][7:0]  <= sram_dout[7:0];
      if (sram_be[1]) sram_mem[sram_addr[5:0]][15:8] <= sram_dout[15:8];
    end
  end

  // Reference memory in core terms: one entry per byte address.
  logic [7:0] bmem [0:127];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int h, input logic [15:0] v);
    pl_en = 1'b1; pl_addr = 6'(h); pl_val = v;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rd = 1'b0; wr = 1'b0;
    #1;
    n_checks++;
    if ({ready, busy, fault, sram_ce, sram_oe, sram_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 000000", {ready, busy, fault, sram_ce, sram_oe, sram_we});
    end
    n_checks++;
    if (rdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h, expected 0000", rdata);
    end
    n_checks++;
    if ({sram_addr, sram_dout, sram_be} !== '0) begin
      n_fail++; $display("FAIL reset_sram_bus: addr %h data %h be %b, expected all 0", sram_addr, sram_dout, sram_be);
    end
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_read_basic;
    preload(8, 16'hBEEF);
    addr = 32'h10; rd = 1'b1; wr = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      rd = 1'b0;
      n_checks++;
      if (ready !== 1'(c == 4)) begin
        n_fail++; $display("FAIL read_ready cycle %0d: got %b, expected %b", c, ready, (c == 4));
      end
      if (c <= 3) begin
        n_checks++;
        if ({sram_ce, sram_oe, sram_we} !== 3'b110 || sram_addr !== 18'h8) begin
          n_fail++; $display("FAIL read_strobes cycle %0d: ce/oe/we %b addr %h, expected 110 addr 8", c, {sram_ce, sram_oe, sram_we}, sram_addr);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (rdata !== 16'hEFBE) begin
          n_fail++; $display("FAIL read_data: got %h, expected efbe", rdata);
        end
      end
    end
  endtask

  task automatic test_write_basic;
    preload(8'h11, 16'h0000);
    addr = 32'h22; wdata = 16'h1234; byte_en = 2'b10; wr = 1'b1; rd = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick;
      wr = 1'b0;
      n_checks++;
      if (sram_we !== 1'(c <= 3)) begin
        n_fail++; $display("FAIL write_we cycle %0d: got %b, expected %b", c, sram_we, (c <= 3));
      end
      if (c <= 3) begin
        n_checks++;
        if (sram_addr !== 18'h11 || sram_be !== 2'b01 || sram_dout !== 16'h3412 || sram_oe !== 1'b0) begin
          n_fail++; $display("FAIL write_bus cycle %0d: addr %h be %b data %h oe %b, expected 11 01 3412 0", c, sram_addr, sram_be, sram_dout, sram_oe);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (ready !== 1'b1) begin
          n_fail++; $display("FAIL write_ready: got %b, expected 1", ready);
        end
      end
    end
    n_checks++;
    if (sram_mem[8'h11] !== 16'h0012) begin
      n_fail++; $display("FAIL write_mem: got %h, expected 0012", sram_mem[8'h11]);
    end
    n_checks++;
    if (rdata !== 16'hEFBE) begin
      n_fail++; $display("FAIL write_keeps_rdata: got %h, expected efbe", rdata);
    end
  endtask

  task automatic test_back_to_back;
    int readies = 0;
    preload(8'h18, 16'h5555);
    preload(8'h20, 16'h7777);
    addr = 32'h30; wdata = 16'hABCD; byte_en = 2'b11; rd = 1'b1; wr = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 1) begin
        rd = 1'b0; wr = 1'b0;
        n_checks++;
        if (sram_we !== 1'b1 || sram_oe !== 1'b0) begin
          n_fail++; $display("FAIL both_is_write: we %b oe %b, expected we 1 oe 0", sram_we, sram_oe);
        end
      end
      if (c == 2) begin addr = 32'h40; rd = 1'b1; end
      if (c == 5) rd = 1'b0;
      if (ready) readies++;
      if (c == 4) begin
        n_checks++;
        if (ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready_cycle4: got %b, expected 1", ready);
        end
      end
    end
    n_checks++;
    if (readies != 1) begin
      n_fail++; $display("FAIL b2b_ready_count: got %0d, expected 1", readies);
    end
    n_checks++;
    if (sram_mem[8'h18] !== 16'hCDAB) begin
      n_fail++; $display("FAIL both_mem: got %h, expected cdab", sram_mem[8'h18]);
    end
    n_checks++;
    if (rdata !== 16'hEFBE) begin
      n_fail++; $display("FAIL ignored_read_rdata: got %h, expected efbe", rdata);
    end
  endtask

  task automatic test_reset_mid;
    int readies = 0;
    preload(8'h28, 16'h1111);
    addr = 32'h50; rd = 1'b1; wr = 1'b0;
    tick;
    rd = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({sram_ce, sram_oe, sram_we, busy, ready} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: ce/oe/we/busy/ready %b, expected 00000", {sram_ce, sram_oe, sram_we, busy, ready});
    end
    n_checks++;
    if (rdata !== 16'h0) begin
      n_fail++; $display("FAIL midreset_rdata: got %h, expected 0000", rdata);
    end
    tick;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (ready || busy) readies++;
    end
    n_checks++;
    if (readies != 0) begin
      n_fail++; $display("FAIL midreset_no_ready: %0d busy/ready cycles, expected 0", readies);
    end
  endtask

  task automatic test_fault;
    int ce_cycles = 0;
    int readies = 0;
    preload(0, 16'h2468);
    addr = 32'h0008_0000; rd = 1'b1; wr = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      rd = 1'b0;
      if (sram_ce) ce_cycles++;
      if (ready) readies++;
`ifdef MEM_PORT_FAULT_CHECK_EN
      if (c <= 2) begin
        n_checks++;
        if (fault !== 1'(c == 1)) begin
          n_fail++; $display("FAIL fault_pulse cycle %0d: got %b, expected %b", c, fault, (c == 1));
        end
      end
`else
      if (c == 4) begin
        n_checks++;
        if (ready !== 1'b1 || rdata !== 16'h6824) begin
          n_fail++; $display("FAIL nofault_read: ready %b data %h, expected 1 6824", ready, rdata);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (sram_addr !== 18'h0 || fault !== 1'b0) begin
          n_fail++; $display("FAIL nofault_addr: addr %h fault %b, expected 0 0", sram_addr, fault);
        end
      end
`endif
    end
`ifdef MEM_PORT_FAULT_CHECK_EN
    n_checks++;
    if (ce_cycles != 0 || readies != 0) begin
      n_fail++; $display("FAIL fault_no_access: ce cycles %0d readies %0d, expected 0 0", ce_cycles, readies);
    end
`else
    n_checks++;
    if (ce_cycles != 3) begin
      n_fail++; $display("FAIL nofault_ce_cycles: got %0d, expected 3", ce_cycles);
    end
`endif
  endtask

  task automatic test_ws0;
    sram0_din = 16'hA55A;
    addr = 32'h10; rd = 1'b1; wr = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick;
      rd = 1'b0;
      n_checks++;
      if (ready0 !== 1'(c == 2)) begin
        n_fail++; $display("FAIL ws0_ready cycle %0d: got %b, expected %b", c, ready0, (c == 2));
      end
      if (c == 2) begin
        n_checks++;
        if (rdata0 !== 16'h5AA5) begin
          n_fail++; $display("FAIL ws0_data: got %h, expected 5aa5", rdata0);
        end
      end
    end
    tick; tick;
  endtask

  task automatic test_random;
    logic [15:0] w, d, exp_rd, last_rd;
    logic [1:0]  be;
    int          op, h, a, lat;
    bit          seen;
    for (int i = 0; i < 64; i++) begin
      w = 16'($urandom);
      bmem[2*i]     = w[7:0];
      bmem[2*i + 1] = w[15:8];
      preload(i, {bmem[2*i + 1], bmem[2*i]});
    end
    reset = 1'b1; tick; reset = 1'b0; tick;
    last_rd = 16'h0;
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 2));
      h  = int'($urandom_range(0, 63));
      a  = 2 * h;
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      addr = 32'(a); wdata = d; byte_en = be;
      rd = (op != 1); wr = (op != 0);
      exp_rd = last_rd;
      if (op != 0) begin
        if (be[1]) bmem[a]     = d[15:8];
        if (be[0]) bmem[a + 1] = d[7:0];
      end else begin
        exp_rd  = {bmem[a], bmem[a + 1]};
        last_rd = exp_rd;
      end
      seen = 1'b0; lat = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
        tick;
        if (ready) begin
          seen = 1'b1; lat = c; rd = 1'b0; wr = 1'b0;
        end else begin
          // Stray requests while busy must be dropped.
          rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
          addr = $urandom; wdata = 16'($urandom); byte_en = 2'($urandom_range(0, 3));
        end
      end
      rd = 1'b0; wr = 1'b0;
      n_checks++;
      if (!seen || lat != WS + 2) begin
        n_fail++; $display("FAIL rand_latency txn %0d: got %0d (seen %0d), expected %0d", t, lat, seen, WS + 2);
      end
      n_checks++;
      if (rdata !== exp_rd) begin
        n_fail++; $display("FAIL rand_rdata txn %0d op %0d addr %h: got %h, expected %h", t, op, a, rdata, exp_rd);
      end
      tick;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick;
    end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (sram_mem[i] !== {bmem[2*i + 1], bmem[2*i]}) begin
        n_fail++; $display("FAIL rand_mem halfword %0d: got %h, expected %h", i, sram_mem[i], {bmem[2*i + 1], bmem[2*i]});
      end
    end
  endtask

  initial begin
    sram0_din = 16'h0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_back_to_back();
    test_reset_mid();
    test_fault();
    test_ws0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
